// File: rtl/eth_frame_fifo.sv
// eth_frame_fifo
//   Single-clock store-and-forward Ethernet frame FIFO. Beats are written
//   speculatively and only become visible to the reader once the whole frame
//   is accepted as good. Bad, oversize or overflowing frames are rewound and
//   counted, so the reader never sees a partial frame.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   s_data/s_valid/s_last write beat, valid, end of frame
//   s_bad                 frame FCS error, sampled with s_last
//   s_ready               write accept (never back-pressures after reset)
//   m_data/m_valid/m_last read beat (first-word fall-through, registered)
//   m_ready               read accept
//   prog_full             fewer than MAX_FRAME_BYTES free entries
//   frame_count           committed frames not yet fully read
//   drop_count            saturating dropped-frame counter
//   drop_pulse            one-cycle pulse per dropped frame
module eth_frame_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 4096,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int DROP_CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  input  logic                      s_bad,
  output logic                      s_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      prog_full,
  output logic [$clog2(DEPTH):0]    frame_count,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      drop_pulse
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int BCW = $clog2(MAX_FRAME_BYTES + 1);

  localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]  MAX_P   = PW'(MAX_FRAME_BYTES);
  localparam logic [BCW-1:0] MAX_BC  = BCW'(MAX_FRAME_BYTES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] rd_q;

  logic [1:0]     state_reg, state_next;
  logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]  wr_commit_reg, wr_commit_next;
  logic [PW-1:0]  rd_ptr_reg;
  logic [BCW-1:0] beat_cnt_reg, beat_cnt_next;
  logic           rd_q_valid_reg;

  logic          beat, full, mem_we, drop_event, commit_event;
  logic [PW-1:0] occupancy;
  logic          out_ready, rd_en, rd_last_xfer;

  assign beat      = s_valid & s_ready;
  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign full      = (occupancy == DEPTH_P);

  // Write-side frame FSM: writes speculatively at wr_ptr, publishes via
  // wr_commit on a good last beat, and rewinds wr_ptr to wr_commit on drop.
  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    wr_commit_next = wr_commit_reg;
    beat_cnt_next  = beat_cnt_reg;
    mem_we         = 1'b0;
    drop_event     = 1'b0;
    commit_event   = 1'b0;
    if (beat) begin
      case (state_reg)
        ST_IDLE: begin
          if (!full) begin
            mem_we        = 1'b1;
            wr_ptr_next   = wr_ptr_reg + PW'(1);
            beat_cnt_next = BCW'(1);
            if (s_last && !s_bad) begin
              wr_commit_next = wr_ptr_reg + PW'(1);
              commit_event   = 1'b1;
            end else if (s_last) begin
              wr_ptr_next = wr_commit_reg;
              drop_event  = 1'b1;
            end else begin
              state_next = ST_WRITE;
            end
          end else if (s_last) begin
            drop_event = 1'b1;
          end else begin
            state_next = ST_DROP;
          end
        end
        ST_WRITE: begin
          if (full || beat_cnt_reg == MAX_BC) begin
            wr_ptr_next = wr_commit_reg;
            if (s_last) begin
              drop_event = 1'b1;
              state_next = ST_IDLE;
            end else begin
              state_next = ST_DROP;
            end
          end else begin
            mem_we        = 1'b1;
            wr_ptr_next   = wr_ptr_reg + PW'(1);
            beat_cnt_next = beat_cnt_reg + BCW'(1);
            if (s_last) begin
              state_next = ST_IDLE;
              if (!s_bad) begin
                wr_commit_next = wr_ptr_reg + PW'(1);
                commit_event   = 1'b1;
              end else begin
                wr_ptr_next = wr_commit_reg;
                drop_event  = 1'b1;
              end
            end
          end
        end
        ST_DROP: begin
          if (s_last) begin
            drop_event = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Read side is a two-stage pipe: the RAM read register (rd_q) feeds the
  // output register. The RAM stage refills whenever it is empty or its
  // content moves on, which gives one beat per cycle with m_ready high.
  assign out_ready    = !m_valid || m_ready;
  assign rd_en        = (rd_ptr_reg != wr_commit_reg) && (!rd_q_valid_reg || out_ready);
  assign rd_last_xfer = m_valid && m_ready && m_last;

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_reg[AW-1:0]] <= {s_last, s_data};
    if (rd_en)  rd_q <= mem[rd_ptr_reg[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      wr_commit_reg  <= '0;
      rd_ptr_reg     <= '0;
      beat_cnt_reg   <= '0;
      rd_q_valid_reg <= 1'b0;
      s_ready        <= 1'b0;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      m_data         <= '0;
      prog_full      <= 1'b0;
      frame_count    <= '0;
      drop_count     <= '0;
      drop_pulse     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      wr_commit_reg <= wr_commit_next;
      beat_cnt_reg  <= beat_cnt_next;
      s_ready       <= 1'b1;

      if (rd_en) begin
        rd_ptr_reg     <= rd_ptr_reg + PW'(1);
        rd_q_valid_reg <= 1'b1;
      end else if (out_ready) begin
        rd_q_valid_reg <= 1'b0;
      end

      if (out_ready) begin
        m_valid <= rd_q_valid_reg;
        if (rd_q_valid_reg) begin
          m_data <= rd_q[DATA_WIDTH-1:0];
          m_last <= rd_q[DATA_WIDTH];
        end
      end

      // Speculative entries count against free space.
      prog_full <= (DEPTH_P - occupancy) < MAX_P;

      case ({commit_event, rd_last_xfer})
        2'b10:   frame_count <= frame_count + 1'b1;
        2'b01:   frame_count <= frame_count - 1'b1;
        default: frame_count <= frame_count;
      endcase

      drop_pulse <= drop_event;
      if (drop_event && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: doc/eth_frame_fifo.md
Name: eth_frame_fifo

Overview:
- Single-clock, store-and-forward Ethernet frame FIFO with parametrised width and depth.
- Generalises the per-port frame-data FIFO.
- A frame becomes visible at the read side only after its last beat is accepted and the frame is good.
- Bad, oversize or overflowing frames are rewound and counted; the read side never sees a partial frame.
- Sits between the MAC RX path and the port's switching matrix.

Parameters:
DATA_WIDTH, 8, beat width in bits
DEPTH, 4096, storage entries; power of two, >= 2*MAX_FRAME_BYTES
MAX_FRAME_BYTES, 1518, beats per frame above which the frame is dropped
DROP_CNT_WIDTH, 16, width of the drop counter

Ports:
clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
s_data  in  DATA_WIDTH  write beat
s_valid  in  1  write beat valid
s_last  in  1  last beat of frame
s_bad  in  1  frame bad (FCS error); sampled only with s_last
s_ready  out  1  write accept
m_data  out  DATA_WIDTH  read beat
m_valid  out  1  read beat valid
m_last  out  1  last beat of frame
m_ready  in  1  read accept
prog_full  out  1  fewer than MAX_FRAME_BYTES free entries
frame_count  out  $clog2(DEPTH)+1  committed frames not fully read
drop_count  out  DROP_CNT_WIDTH  frames dropped; saturating
drop_pulse  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset (async assert, sync release): all pointers 0; FSM to IDLE.
  - s_ready=0, m_valid=0, m_last=0, m_data=0, prog_full=0, frame_count=0, drop_count=0, drop_pulse=0.
  - s_ready goes 1 on the first clock after release and stays 1. The writer is never back-pressured; overflow is handled by dropping.
  - Reset mid-frame discards everything, including committed frames.
- Storage: DEPTH x (DATA_WIDTH+1); the extra bit holds last.
- Pointers: wr_ptr (speculative), wr_commit, rd_ptr, each $clog2(DEPTH)+1 bits. Wrap is natural modulo 2*DEPTH.
- Occupancy = wr_ptr - rd_ptr. Full when occupancy == DEPTH.
- FSM states: IDLE, WRITE, DROP. "Beat" = s_valid & s_ready. beat_cnt counts beats of the current frame.
  - IDLE, beat, not full:
    - Write the beat, beat_cnt=1.
    - If s_last & !s_bad: commit (wr_commit <= wr_ptr+1), stay IDLE.
    - If s_last & s_bad: rewind, drop, stay IDLE.
    - Otherwise go to WRITE.
  - IDLE, beat, full:
    - If s_last: drop, stay IDLE.
    - Otherwise go to DROP.
  - WRITE, beat:
    - If full, or beat_cnt == MAX_FRAME_BYTES: rewind (wr_ptr <= wr_commit); go to DROP, or drop immediately and go to IDLE if s_last.
    - Otherwise write the beat and increment beat_cnt.
    - On s_last: commit if !s_bad, else rewind and drop; go to IDLE.
  - DROP, beat: discard the beat. On s_last: drop, go to IDLE.
- Drop:
  - drop_pulse=1 for the cycle after the event.
  - drop_count increments, saturating at all-ones.
  - Exactly one drop per frame.
- Read side (first-word fall-through, registered output):
  - Data available when rd_ptr != wr_commit.
  - After a commit at edge N, m_valid=1 from edge N+2, when the output register was empty.
  - m_data and m_last hold stable while m_valid & !m_ready.
  - With m_ready held high, one beat transfers per cycle with no bubbles.
- frame_count:
  - +1 on commit; -1 on an m_valid & m_ready & m_last transfer.
  - Both in the same cycle leave it unchanged.
- prog_full = registered (DEPTH - occupancy < MAX_FRAME_BYTES). Occupancy counts speculative entries.
- Reads and writes in the same cycle are both honoured. Rewinding wr_ptr never moves rd_ptr.

Test Plan:
- DEPTH=64, MAX=32. Write one good 10-beat frame 0x01..0x0A, m_ready=1 -> m_valid rises 2 cycles after the last beat; beats 0x01..0x0A in order; m_last only on 0x0A; frame_count goes 1 then 0.
- 10-beat frame with s_bad=1 on last -> m_valid never rises; drop_count=1; one drop_pulse; a following good 4-beat frame reads out intact.
- 40-beat frame -> dropped at beat 33, beats 33..40 discarded; drop_count=1; wr_ptr equals the pre-frame value.
- m_ready=0; write good 30-beat frames -> frames 1 and 2 commit (frame_count=2, prog_full=1); frame 3 hits full and is dropped; releasing m_ready yields exactly 60 beats.
- m_ready toggling 1,0,1,0 during readout -> no beat duplicated or lost; m_data stable while stalled.
- Assert reset_n=0 mid-frame with one committed frame -> all outputs at reset values asynchronously; after release FIFO is empty and the next good frame passes.
